alu_flag_gen: RTL and testbench

//  Multi-cycle flag producer for the pipeline compare path: computes A+B or A-B a CHUNK-bit slice
//  per cycle and delivers the registered Z (zero), V (signed overflow) and N (negative) flags.

---
 rtl/alu_flag_gen.sv | 109 ++++++++++
 tb/tb_alu_flag_gen.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_flag_gen.sv
// alu_flag_gen: multi-cycle CHUNK-bit-per-cycle add/sub producing registered Z/V/N flags.
// Define ALU_FLAG_CARRY_EN to add the unsigned carry-out flag port C.
module alu_flag_gen #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             Z,
  output logic             V,
  output logic             N
`ifdef ALU_FLAG_CARRY_EN
  ,
  output logic             C
`endif
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic sub_q, carry_q, zacc_q, z_q, v_q, n_q, out_valid_q;
  logic [IW-1:0] idx_q;
  logic [CHUNK-1:0] a_sl, b_sl;
  logic [CHUNK:0] s;
  logic last, zacc_d, v_d;
`ifdef ALU_FLAG_CARRY_EN
  logic c_q;
  assign C = c_q;
`endif
  if (WIDTH % CHUNK != 0) begin : g_bad_cfg
    $error("alu_flag_gen: WIDTH must be a multiple of CHUNK");
  end
  // Operands shift right each RUN cycle, so the active slice is always the low CHUNK bits.
  always_comb begin
    a_sl = a_q[CHUNK-1:0];
    b_sl = b_q[CHUNK-1:0] ^ {CHUNK{sub_q}};
    s = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
    zacc_d = zacc_q & (s[CHUNK-1:0] == '0);
    v_d = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ s[CHUNK-1] ^ s[CHUNK];
    last = idx_q == IW'(NCH - 1);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sub_q <= 1'b0;
      carry_q <= 1'b0;
      zacc_q <= 1'b0;
      idx_q <= '0;
      z_q <= 1'b0;
      v_q <= 1'b0;
      n_q <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ALU_FLAG_CARRY_EN
      c_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q <= a;
          b_q <= b;
          sub_q <= sub;
          carry_q <= sub;
          zacc_q <= 1'b1;
          idx_q <= '0;
          state_q <= RUN;
        end
        RUN: begin
          a_q <= a_q >> CHUNK;
          b_q <= b_q >> CHUNK;
          carry_q <= s[CHUNK];
          zacc_q <= zacc_d;
          idx_q <= last ? '0 : idx_q + IW'(1);
          if (last) begin
            z_q <= zacc_d;
            n_q <= s[CHUNK-1];
            v_q <= v_d;
`ifdef ALU_FLAG_CARRY_EN
            c_q <= s[CHUNK];
`endif
            out_valid_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign out_valid = out_valid_q;
  assign Z = z_q;
  assign V = v_q;
  assign N = n_q;
endmodule

// File: tb/tb_alu_flag_gen.sv
// tb_alu_flag_gen: randomized and directed checks of alu_flag_gen (CHUNK=8 and CHUNK=32 builds).
module tb_alu_flag_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic in_valid = 1'b0, out_ready = 1'b0, sub = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic in_ready, out_valid, busy, Z, V, N;
  logic f_in_valid = 1'b0, f_out_ready = 1'b0;
  logic f_in_ready, f_out_valid, f_busy, fz, fv, fn;
`ifdef ALU_FLAG_CARRY_EN
  logic C, fc;
`endif
  int errors = 0, checks = 0;

  alu_flag_gen #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .Z(Z), .V(V), .N(N)
`ifdef ALU_FLAG_CARRY_EN
    , .C(C)
`endif
  );

  alu_flag_gen #(.WIDTH(32), .CHUNK(32)) u_full (
    .clk(clk), .reset(reset), .in_valid(f_in_valid), .in_ready(f_in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(f_out_valid), .out_ready(f_out_ready),
    .busy(f_busy), .Z(fz), .V(fv), .N(fn)
`ifdef ALU_FLAG_CARRY_EN
    , .C(fc)
`endif
  );

  // Reference: exact integer arithmetic; returns {Z,N,V,C}.
  function automatic logic [3:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint sx, sy, t;
    logic [32:0] u;
    logic [31:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    t = s ? sx - sy : sx + sy;
    u = {1'b0, x} + {1'b0, y};
    r = t[31:0];
    return {r == 32'd0, r[31],
            (t > longint'(32'sh7FFFFFFF)) || (t < longint'(32'sh80000000)),
            s ? (x >= y) : u[32]};
  endfunction

  task automatic run_op(input bit sel, input logic [31:0] x, input logic [31:0] y,
                        input logic s, output int lat);
    int w;
    a = x;
    b = y;
    sub = s;
    if (sel) f_in_valid = 1'b1;
    else in_valid = 1'b1;
    w = 0;
    while (!(sel ? f_in_ready : in_ready) && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    f_in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    sub = 1'($urandom);
    lat = 0;
    while (!(sel ? f_out_valid : out_valid) && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handoff(input bit sel);
    if (sel) f_out_ready = 1'b1;
    else out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    f_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({out_valid, busy, Z, N, V} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got ov/busy/Z/N/V=%b want 00000", {out_valid, busy, Z, N, V});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
`ifdef ALU_FLAG_CARRY_EN
    checks++;
    if (C !== 1'b0) begin
      errors++;
      $display("FAIL reset_C: got %b want 0", C);
    end
`endif
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  logic [31:0] va[4] = '{32'd5, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
  logic [31:0] vb[4] = '{32'd5, 32'd1, 32'd1, 32'd1};
  logic vs[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [3:0] vexp[4] = '{4'b1001, 4'b0110, 4'b0011, 4'b1001};

  task automatic test_vectors();
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, va[i], vb[i], vs[i], lat);
      checks++;
      if (lat !== 4) begin
        errors++;
        $display("FAIL vec%0d_latency: got %0d want 4", i, lat);
      end
      checks++;
      if ({Z, N, V} !== vexp[i][3:1] || busy !== 1'b1) begin
        errors++;
        $display("FAIL vec%0d_flags: got ZNV=%b busy=%b want %b 1", i, {Z, N, V}, busy, vexp[i][3:1]);
      end
`ifdef ALU_FLAG_CARRY_EN
      checks++;
      if (C !== vexp[i][0]) begin
        errors++;
        $display("FAIL vec%0d_C: got %b want %b", i, C, vexp[i][0]);
      end
`endif
      handoff(1'b0);
    end
  endtask

  task automatic test_stall();
    int lat;
    run_op(1'b0, 32'd3, 32'd7, 1'b1, lat);
    checks++;
    if (lat !== 4 || {Z, N, V} !== 3'b010) begin
      errors++;
      $display("FAIL stall_first: got lat=%0d ZNV=%b want 4 010", lat, {Z, N, V});
    end
    a = 32'h7FFFFFFF;
    b = 32'd1;
    sub = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {Z, N, V} !== 3'b010) begin
        errors++;
        $display("FAIL stall_hold%0d: got ov=%b in_ready=%b ZNV=%b want 1 0 010",
                 i, out_valid, in_ready, {Z, N, V});
      end
    end
    handoff(1'b0);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || {Z, N, V} !== 3'b010) begin
      errors++;
      $display("FAIL stall_handoff: got ov=%b in_ready=%b ZNV=%b want 0 1 010",
               out_valid, in_ready, {Z, N, V});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_accept: got busy=%b in_ready=%b want 1 0", busy, in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat !== 4 || {Z, N, V} !== 3'b011) begin
      errors++;
      $display("FAIL stall_second: got lat=%0d ZNV=%b want 4 011", lat, {Z, N, V});
    end
  endtask

  task automatic test_reset_mid();
    int lat, seen;
    handoff(1'b0);
    a = 32'd0;
    b = 32'd0;
    sub = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || {Z, N, V} !== 3'b000 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: got ov=%b ZNV=%b in_ready=%b busy=%b want 0 000 1 0",
               out_valid, {Z, N, V}, in_ready, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midrun_no_pulse: got %0d out_valid cycles want 0", seen);
    end
    run_op(1'b0, 32'hFFFFFFFF, 32'd1, 1'b0, lat);
    checks++;
    if (lat !== 4 || {Z, N, V} !== 3'b100) begin
      errors++;
      $display("FAIL after_reset_op: got lat=%0d ZNV=%b want 4 100", lat, {Z, N, V});
    end
`ifdef ALU_FLAG_CARRY_EN
    checks++;
    if (C !== 1'b1) begin
      errors++;
      $display("FAIL after_reset_C: got %b want 1", C);
    end
`endif
    handoff(1'b0);
  endtask

  task automatic test_back_to_back();
    int lat, stall;
    logic [31:0] x, y;
    logic s;
    logic [3:0] e;
    for (int i = 0; i < 8; i++) begin
      x = $urandom;
      y = (i % 3 == 0) ? x : 32'($urandom);
      s = 1'($urandom);
      e = model(x, y, s);
      run_op(1'b0, x, y, s, lat);
      checks++;
      if (lat !== 4 || {Z, N, V} !== e[3:1]) begin
        errors++;
        $display("FAIL b2b%0d: a=%h b=%h sub=%b got lat=%0d ZNV=%b want 4 %b",
                 i, x, y, s, lat, {Z, N, V}, e[3:1]);
      end
`ifdef ALU_FLAG_CARRY_EN
      checks++;
      if (C !== e[0]) begin
        errors++;
        $display("FAIL b2b%0d_C: got %b want %b", i, C, e[0]);
      end
`endif
      stall = $urandom_range(0, 3);
      for (int k = 0; k < stall; k++) begin
        @(posedge clk);
        #1;
      end
      checks++;
      if (out_valid !== 1'b1 || {Z, N, V} !== e[3:1]) begin
        errors++;
        $display("FAIL b2b%0d_stall: got ov=%b ZNV=%b want 1 %b", i, out_valid, {Z, N, V}, e[3:1]);
      end
      handoff(1'b0);
    end
  endtask

  task automatic test_chunk_full();
    int lat;
    logic [3:0] e;
    for (int i = 0; i < 5; i++) begin
      logic [31:0] x, y;
      logic s;
      x = (i < 4) ? va[i] : 32'($urandom);
      y = (i < 4) ? vb[i] : 32'($urandom);
      s = (i < 4) ? vs[i] : 1'($urandom);
      e = model(x, y, s);
      run_op(1'b1, x, y, s, lat);
      checks++;
      if (lat !== 1 || {fz, fn, fv} !== e[3:1]) begin
        errors++;
        $display("FAIL full%0d: a=%h b=%h sub=%b got lat=%0d ZNV=%b want 1 %b",
                 i, x, y, s, lat, {fz, fn, fv}, e[3:1]);
      end
`ifdef ALU_FLAG_CARRY_EN
      checks++;
      if (fc !== e[0]) begin
        errors++;
        $display("FAIL full%0d_C: got %b want %b", i, fc, e[0]);
      end
`endif
      handoff(1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_chunk_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
